// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and parameter defaults for the IO controller
package io_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int TX_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_SEND = 2'd1,
    OUT_HOLD = 2'd2
  } out_state_e;

endpackage

// File: rtl/io_if.sv
// rtl/io_if.sv - device-side handshake bundle for the IO controller
interface io_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] dev_in_data;
  logic              dev_in_valid;
  logic              dev_in_ready;
  logic [DATA_W-1:0] dev_out_data;
  logic              dev_out_valid;
  logic              dev_out_ready;

  // Device side: presents input bytes, consumes output bytes
  modport master (
    output dev_in_data,
    output dev_in_valid,
    input  dev_in_ready,
    input  dev_out_data,
    input  dev_out_valid,
    output dev_out_ready
  );

  // Controller side
  modport slave (
    input  dev_in_data,
    input  dev_in_valid,
    output dev_in_ready,
    output dev_out_data,
    output dev_out_valid,
    input  dev_out_ready
  );

endinterface

// File: rtl/io_tx_fsm.sv
// rtl/io_tx_fsm.sv - output register, transmit FSM and post-handshake busy counter
module io_tx_fsm
  import io_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TX_HOLD = TX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_out,
  input  logic [DATA_W-1:0] cpu_ac,
  input  logic              dev_out_ready,
  output logic [DATA_W-1:0] outr,
  output logic              out_valid,
  output logic              fgo,
  output logic              out_err
);

  out_state_e        r_state;
  out_state_e        w_next_state;
  logic [7:0]        r_cnt;
  logic [7:0]        w_next_cnt;
  logic [DATA_W-1:0] r_outr;
  logic [DATA_W-1:0] w_next_outr;
  logic              w_err;

  // State, counter and OUTR registers; reset abandons any byte in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_IDLE;
      r_cnt   <= 8'd0;
      r_outr  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_outr  <= w_next_outr;
    end
  end

  // Next-state logic; the device stays busy TX_HOLD cycles after its handshake
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_outr  = r_outr;
    w_err        = 1'b0;
    unique case (r_state)
      OUT_IDLE: begin
        if (cpu_out) begin
          w_next_outr  = cpu_ac;
          w_next_state = OUT_SEND;
        end
      end
      OUT_SEND: begin
        w_err = cpu_out;
        if (dev_out_ready) begin
          w_next_state = OUT_HOLD;
          w_next_cnt   = 8'(TX_HOLD - 1);
        end
      end
      OUT_HOLD: begin
        w_err = cpu_out;
        if (r_cnt == 8'd0) begin
          w_next_state = OUT_IDLE;
        end else begin
          w_next_cnt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_next_state = OUT_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
  end

  assign outr      = r_outr;
  assign out_valid = (r_state == OUT_SEND);
  assign fgo       = (r_state == OUT_IDLE);
  assign out_err   = w_err;

endmodule

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - IO controller: input capture, flags, interrupt logic, transmit FSM
module io_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TX_HOLD = TX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  io_if.slave               dev,
  input  logic [DATA_W-1:0] cpu_ac,
  input  logic              cpu_inp,
  input  logic              cpu_out,
  input  logic              cpu_ion,
  input  logic              cpu_iof,
  input  logic              cpu_ack,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              irq,
  output logic              err
);

  logic [DATA_W-1:0] r_inpr;
  logic              r_fgi;
  logic              r_ien;
  logic              r_irq;
  logic              r_err;
  logic [DATA_W-1:0] w_outr;
  logic              w_out_valid;
  logic              w_fgo;
  logic              w_tx_err;

  io_tx_fsm #(
    .DATA_W  (DATA_W),
    .TX_HOLD (TX_HOLD)
  ) u_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_out       (cpu_out),
    .cpu_ac        (cpu_ac),
    .dev_out_ready (dev.dev_out_ready),
    .outr          (w_outr),
    .out_valid     (w_out_valid),
    .fgo           (w_fgo),
    .out_err       (w_tx_err)
  );

  // Input capture: a CPU read frees INPR, but the byte offered that same cycle waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inpr <= '0;
      r_fgi  <= 1'b0;
    end else if (cpu_inp && r_fgi) begin
      r_fgi <= 1'b0;
    end else if (!r_fgi && dev.dev_in_valid) begin
      r_inpr <= dev.dev_in_data;
      r_fgi  <= 1'b1;
    end
  end

  // Interrupt enable and registered request; IOF and ACK both beat ION
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (cpu_iof || cpu_ack) begin
        r_ien <= 1'b0;
      end else if (cpu_ion) begin
        r_ien <= 1'b1;
      end
      r_irq <= cpu_ack ? 1'b0 : (r_ien & (r_fgi | w_fgo));
    end
  end

  // Sticky protocol error: read with nothing pending, write while busy, stray ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((cpu_inp && !r_fgi) || w_tx_err || (cpu_ack && !r_irq)) begin
      r_err <= 1'b1;
    end
  end

  assign dev.dev_in_ready  = !r_fgi;
  assign dev.dev_out_data  = w_outr;
  assign dev.dev_out_valid = w_out_valid;
  assign inpr              = r_inpr;
  assign fgi               = r_fgi;
  assign fgo               = w_fgo;
  assign ien               = r_ien;
  assign irq               = r_irq;
  assign err               = r_err;

endmodule
